sample_log_ram: RTL and testbench

SAMPLE_LOG_RAM -- requirements
Module: sample_log_ram

---
 rtl/sample_log_ram.sv | 217 +++++++++++++++++++++
 tb/tb_sample_log_ram.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_log_ram.sv
// sample_log_ram
// ----------------------------------------------------------------------------
// Block-RAM sample logger. An armed capture stores valid samples in write
// order, either one-shot (stop when the RAM is full) or circular (keep
// overwriting the oldest sample and flag overflow). The logged samples are
// then streamed out in write order through a valid/ready interface. A
// readout can be repeated as often as needed.
//
// Build option: define SAMPLE_LOG_RAM_OUTREG_EN to add an output register
// after the RAM. RAM-to-port latency goes from 1 to 2 cycles and throughput
// does not change. The default build leaves the macro undefined.
//
// Parameters
//   DATA_W   sample width in bits
//   DEPTH    number of stored samples (power of two, >= 4)
//   ADDR_W   pointer width, derived from DEPTH
//
// Ports
//   clock      single clock for all logic
//   rstb       synchronous, active-high reset (memory contents are kept)
//   cap_start  pulse: arm a capture (from IDLE or DONE)
//   cap_mode   0 = one-shot, 1 = circular; sampled with cap_start
//   cap_stop   pulse: end the capture
//   in_valid   in_data holds a valid sample this cycle
//   in_data    sample to store
//   cap_busy   high while capturing
//   cap_done   high in DONE (data available for readout)
//   overflow   sticky: a circular capture overwrote data
//   wr_count   number of valid stored samples (0..DEPTH)
//   rd_start   pulse: start readout (from DONE)
//   rd_valid   rd_data is valid
//   rd_ready   consumer accepts rd_data
//   rd_data    read sample
//   rd_last    rd_data is the final sample of this readout
// ----------------------------------------------------------------------------
module sample_log_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rstb,
  input  logic              cap_start,
  input  logic              cap_mode,
  input  logic              cap_stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count,
  input  logic              rd_start,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] READOUT = 2'd3;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_FILL  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  logic [1:0]        state_reg, state_next;
  logic              mode_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   issue_reg;     // samples still to be fetched from RAM
  logic              ovf_reg;

  // Sample storage: starts at zero at configuration and is never reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // First read stage: the RAM's own registered read port.
  logic [DATA_W-1:0] ram_q_reg;
  logic              ram_v_reg;
  logic              ram_last_reg;

  logic wr_en;
  logic cap_arm;
  logic ram_load;
  logic ram_pop;
  logic ram_free;
  logic final_xfer;

  assign wr_en      = (state_reg == CAPTURE) && in_valid;
  assign cap_arm    = cap_start && ((state_reg == IDLE) || (state_reg == DONE));
  assign ram_free   = !ram_v_reg || ram_pop;
  assign ram_load   = (state_reg == READOUT) && (issue_reg != '0) && ram_free;
  assign final_xfer = rd_valid && rd_ready && rd_last;

  assign cap_busy = (state_reg == CAPTURE);
  assign cap_done = (state_reg == DONE);
  assign overflow = ovf_reg;
  assign wr_count = count_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cap_start) state_next = CAPTURE;
      end
      CAPTURE: begin
        // In one-shot mode the write that fills the RAM is the final one.
        if (cap_stop || (!mode_reg && in_valid && (count_reg == LAST_FILL)))
          state_next = DONE;
      end
      DONE: begin
        if (cap_start)
          state_next = CAPTURE;
        else if (rd_start && (count_reg != '0))
          state_next = READOUT;
      end
      READOUT: begin
        if (final_xfer) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rstb) begin
      state_reg  <= IDLE;
      mode_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      rd_ptr_reg <= '0;
      issue_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (cap_arm) begin
        mode_reg   <= cap_mode;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
        ovf_reg    <= 1'b0;
      end else if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_ONE;  // wraps: DEPTH is a power of two
        if (count_reg == FULL_COUNT)
          ovf_reg <= 1'b1;                    // only reachable in circular mode
        else
          count_reg <= count_reg + COUNT_ONE;
      end

      // Oldest sample sits at 0 unless the buffer wrapped, then at wr_ptr.
      if ((state_reg == DONE) && (state_next == READOUT)) begin
        rd_ptr_reg <= ovf_reg ? wr_ptr_reg : '0;
        issue_reg  <= count_reg;
      end else if (ram_load) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_ONE;
        issue_reg  <= issue_reg - COUNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= in_data;
  end

  // The read register only loads when its current content is consumed, so
  // it doubles as the stall-holding stage.
  always_ff @(posedge clock) begin
    if (rstb) begin
      ram_q_reg    <= '0;
      ram_v_reg    <= 1'b0;
      ram_last_reg <= 1'b0;
    end else if (ram_load) begin
      ram_q_reg    <= mem[rd_ptr_reg];
      ram_v_reg    <= 1'b1;
      ram_last_reg <= (issue_reg == COUNT_ONE);
    end else if (ram_pop) begin
      ram_v_reg    <= 1'b0;
      ram_last_reg <= 1'b0;
    end
  end

`ifdef SAMPLE_LOG_RAM_OUTREG_EN
  logic [DATA_W-1:0] out_q_reg;
  logic              out_v_reg;
  logic              out_last_reg;

  // RAM stage moves forward whenever the output stage is empty or draining.
  assign ram_pop = ram_v_reg && (!out_v_reg || rd_ready);

  always_ff @(posedge clock) begin
    if (rstb) begin
      out_q_reg    <= '0;
      out_v_reg    <= 1'b0;
      out_last_reg <= 1'b0;
    end else if (ram_pop) begin
      out_q_reg    <= ram_q_reg;
      out_v_reg    <= 1'b1;
      out_last_reg <= ram_last_reg;
    end else if (out_v_reg && rd_ready) begin
      out_v_reg    <= 1'b0;
      out_last_reg <= 1'b0;
    end
  end

  assign rd_valid = out_v_reg;
  assign rd_data  = out_q_reg;
  assign rd_last  = out_last_reg;
`else
  assign ram_pop  = ram_v_reg && rd_ready;
  assign rd_valid = ram_v_reg;
  assign rd_data  = ram_q_reg;
  assign rd_last  = ram_last_reg;
`endif

endmodule

// File: tb/tb_sample_log_ram.sv
// tb_sample_log_ram
// ----------------------------------------------------------------------------
// Directed bench for sample_log_ram with DEPTH=16 and DATA_W=32. A small
// behavioural model of the log (contents, write position, count, overflow)
// fills a scoreboard queue when a readout is started. Each transferred
// sample is popped and compared. Also covers reset values, ignored inputs,
// stall stability, first-valid latency (either build) and reset mid-operation.
// ----------------------------------------------------------------------------
module tb_sample_log_ram;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
`ifdef SAMPLE_LOG_RAM_OUTREG_EN
  localparam int FIRST_LAT = 3;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic              clock = 1'b0;
  logic              rstb;
  logic              cap_start;
  logic              cap_mode;
  logic              cap_stop;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              cap_busy;
  logic              cap_done;
  logic              overflow;
  logic [AW:0]       wr_count;
  logic              rd_start;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  sample_log_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .rstb(rstb),
    .cap_start(cap_start), .cap_mode(cap_mode), .cap_stop(cap_stop),
    .in_valid(in_valid), .in_data(in_data),
    .cap_busy(cap_busy), .cap_done(cap_done), .overflow(overflow),
    .wr_count(wr_count),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the log.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                m_ptr;
  int                m_cnt;
  logic              m_ovf;

  // Scoreboard entries: {last, data}.
  logic [DATA_W:0] sb [$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_write(input logic [DATA_W-1:0] d);
    model_mem[m_ptr] = d;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_cnt == DEPTH) m_ovf = 1'b1;
    else m_cnt++;
  endtask

  task automatic do_reset();
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    model_clear();
  endtask

  task automatic cap_begin(input logic mode);
    cap_start = 1'b1;
    cap_mode  = mode;
    step();
    cap_start = 1'b0;
    cap_mode  = 1'b0;
    model_clear();
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    model_write(d);
  endtask

  task automatic stop_cap(input logic v, input logic [DATA_W-1:0] d);
    cap_stop = 1'b1;
    in_valid = v;
    in_data  = d;
    step();
    cap_stop = 1'b0;
    in_valid = 1'b0;
    if (v) model_write(d);
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s_busy", tag), cap_busy, 0);
    chk($sformatf("%s_done", tag), cap_done, 0);
    chk($sformatf("%s_ovf", tag), overflow, 0);
    chk($sformatf("%s_count", tag), wr_count, 0);
    chk($sformatf("%s_rdvalid", tag), rd_valid, 0);
    chk($sformatf("%s_rdlast", tag), rd_last, 0);
    chk($sformatf("%s_rddata", tag), rd_data, 0);
  endtask

  // Start a readout and drain it with rd_ready following ready_pat
  // (bit k used on the k-th cycle that rd_valid is high, modulo 4).
  task automatic read_all(input string tag, input logic [3:0] ready_pat, input bit full_rate);
    int n, base, cyc, first_cyc, last_cyc, xfers, vcnt;
    bit fin, stalled;
    logic [DATA_W-1:0] held_d;
    logic held_l;
    logic [DATA_W:0] e;
    n    = m_cnt;
    base = m_ovf ? m_ptr : 0;
    for (int i = 0; i < n; i++)
      sb.push_back({(i == n - 1), model_mem[(base + i) % DEPTH]});
    rd_start = 1'b1;
    step();
    rd_start  = 1'b0;
    cyc       = 1;
    first_cyc = -1;
    last_cyc  = -1;
    xfers     = 0;
    vcnt      = 0;
    fin       = 1'b0;
    stalled   = 1'b0;
    held_d    = '0;
    held_l    = 1'b0;
    while (!fin && cyc < 200) begin
      if (stalled) begin
        chk($sformatf("%s_stall_valid", tag), rd_valid, 1);
        chk($sformatf("%s_stall_data", tag), rd_data, held_d);
        chk($sformatf("%s_stall_last", tag), rd_last, held_l);
      end
      if (rd_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      rd_ready = ready_pat[vcnt % 4];
      stalled  = 1'b0;
      if (rd_valid === 1'b1) begin
        vcnt++;
        if (rd_ready) begin
          if (sb.size() == 0) begin
            chk($sformatf("%s_extra_sample", tag), rd_data, 0);
            fin = 1'b1;
          end else begin
            e = sb.pop_front();
            $display("rd %s #%0d data=0x%08h last=%0b", tag, xfers, rd_data, rd_last);
            chk($sformatf("%s_data%0d", tag, xfers), rd_data, e[DATA_W-1:0]);
            chk($sformatf("%s_last%0d", tag, xfers), rd_last, e[DATA_W]);
            xfers++;
            last_cyc = cyc;
            if (e[DATA_W]) fin = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          held_d  = rd_data;
          held_l  = rd_last;
        end
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    chk($sformatf("%s_finished_in_budget", tag), fin, 1);
    chk($sformatf("%s_first_valid_cycle", tag), first_cyc, FIRST_LAT);
    chk($sformatf("%s_transfers", tag), xfers, n);
    if (full_rate) chk($sformatf("%s_back_to_back", tag), last_cyc - first_cyc, n - 1);
    chk($sformatf("%s_sb_empty", tag), sb.size(), 0);
    chk($sformatf("%s_back_in_done", tag), cap_done, 1);
    chk($sformatf("%s_valid_dropped", tag), rd_valid, 0);
    chk($sformatf("%s_count_held", tag), wr_count, m_cnt);
    chk($sformatf("%s_ovf_held", tag), overflow, m_ovf);
    sb.delete();
  endtask

  initial begin
    rstb      = 1'b1;
    cap_start = 1'b0;
    cap_mode  = 1'b0;
    cap_stop  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    rd_start  = 1'b0;
    rd_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_clear();
    step();
    step();
    rstb = 1'b0;
    check_zero("reset");

    // Inputs that must be ignored in IDLE.
    in_valid = 1'b1;
    in_data  = 32'h55;
    cap_stop = 1'b1;
    rd_start = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    cap_stop = 1'b0;
    rd_start = 1'b0;
    step();
    check_zero("idle_ignore");

    // One-shot fill of 16 samples, then readout at full rate.
    cap_begin(1'b0);
    chk("os_busy", cap_busy, 1);
    for (int i = 0; i < DEPTH; i++) push(32'h100 + i);
    chk("os_auto_done", cap_done, 1);
    chk("os_busy_off", cap_busy, 0);
    chk("os_count", wr_count, 16);
    chk("os_ovf", overflow, 0);
    // in_valid while DONE must not write or count.
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    step();
    in_valid = 1'b0;
    chk("done_ignore_count", wr_count, 16);
    chk("done_ignore_ovf", overflow, 0);
    read_all("oneshot", 4'b1111, 1'b1);

    // Circular capture of 20 samples: oldest four overwritten.
    cap_begin(1'b1);
    for (int i = 0; i < 20; i++) push(i);
    chk("circ_still_busy", cap_busy, 1);
    chk("circ_count", wr_count, 16);
    chk("circ_ovf", overflow, 1);
    stop_cap(1'b0, '0);
    chk("circ_done", cap_done, 1);
    read_all("circular", 4'b1111, 1'b1);

    // Stop with a sample in the same cycle: that sample is the last.
    cap_begin(1'b0);
    chk("stopwr_ovf_cleared", overflow, 0);
    for (int i = 0; i < 5; i++) push(32'hA0 + i);
    stop_cap(1'b1, 32'hA5);
    chk("stopwr_count", wr_count, 6);
    chk("stopwr_done", cap_done, 1);
    read_all("stopwr", 4'b1111, 1'b1);

    // Back-pressure pattern 1,0,0,1, then re-read the same data.
    read_all("stall", 4'b1001, 1'b0);
    read_all("reread", 4'b1111, 1'b1);

    // Capture with zero samples: rd_start must not start a readout.
    cap_begin(1'b0);
    stop_cap(1'b0, '0);
    chk("empty_done", cap_done, 1);
    chk("empty_count", wr_count, 0);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("empty_novalid%0d", i), rd_valid, 0);
      step();
    end
    rd_ready = 1'b0;
    chk("empty_stays_done", cap_done, 1);

    // Reset in the middle of a capture.
    cap_begin(1'b0);
    for (int i = 0; i < 7; i++) push(32'h700 + i);
    chk("midcap_count", wr_count, 7);
    do_reset();
    check_zero("rst_midcap");

    // Reset in the middle of a readout.
    cap_begin(1'b1);
    for (int i = 0; i < 7; i++) push(32'h800 + i);
    stop_cap(1'b0, '0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    step();
    step();
    step();
    chk("midread_active", rd_valid, 1);
    do_reset();
    rd_ready = 1'b0;
    check_zero("rst_midread");

    // A fresh three-sample capture reads back exactly those three.
    cap_begin(1'b0);
    push(32'hC0);
    push(32'hC1);
    push(32'hC2);
    stop_cap(1'b0, '0);
    chk("after_rst_count", wr_count, 3);
    read_all("after_rst", 4'b1111, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
